// File: rtl/alu_issue_stage.sv
// Issue buffer in front of the ALU adder: decodes the adder operands and control code,
// then queues them in a 2-entry registered FIFO whose head drives the adder directly.
//
// state | meaning
// EMPTY | no entries, out_valid low
// ONE   | one entry at rd_ptr, can accept and issue in the same cycle
// FULL  | both entries occupied, in_ready low
module alu_issue_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [63:0] in_rs1,
    input  logic [63:0] in_rs2,
    input  logic [63:0] in_imm,
    input  logic [63:0] in_pc,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_src1,
    output logic [63:0] out_src2,
    output logic [3:0]  out_control,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fill_t;

    fill_t       count;
    logic        wr_ptr;
    logic        rd_ptr;
    logic        push;
    logic        pop;

    logic [63:0] src1_mem    [DEPTH];
    logic [63:0] src2_mem    [DEPTH];
    logic [3:0]  ctl_mem     [DEPTH];
    logic [4:0]  rd_mem      [DEPTH];
    logic        illegal_mem [DEPTH];

    logic [63:0] sel_src1;
    logic [63:0] sel_src2;
    logic [3:0]  sel_ctl;
    logic        sel_illegal;

    always_comb begin
        sel_src1    = 64'd0;
        sel_src2    = 64'd0;
        sel_ctl     = 4'd0;
        sel_illegal = 1'b0;
        case (in_op)
            4'd0:  begin sel_src1 = in_rs1; sel_src2 = in_rs2; sel_ctl = 4'd0; end
            4'd1:  begin sel_src1 = in_rs1; sel_src2 = in_rs2; sel_ctl = 4'd1; end
            4'd2:  begin sel_src1 = in_rs1; sel_src2 = in_imm; sel_ctl = 4'd0; end
            4'd3:  begin sel_src1 = in_rs1; sel_src2 = in_rs2; sel_ctl = 4'd2; end
            4'd4:  begin sel_src1 = in_rs1; sel_src2 = in_rs2; sel_ctl = 4'd3; end
            4'd5:  begin sel_src1 = in_rs1; sel_src2 = in_imm; sel_ctl = 4'd2; end
            4'd6:  begin sel_src1 = 64'd0;  sel_src2 = in_imm; sel_ctl = 4'd0; end
            4'd7:  begin sel_src1 = in_pc;  sel_src2 = in_imm; sel_ctl = 4'd0; end
            4'd8:  begin sel_src1 = in_pc;  sel_src2 = 64'd4;  sel_ctl = 4'd0; end
            4'd9:  begin sel_src1 = in_rs1; sel_src2 = in_imm; sel_ctl = 4'd4; end
            4'd10: begin sel_src1 = in_rs1; sel_src2 = in_imm; sel_ctl = 4'd0; end
            default: sel_illegal = 1'b1;
        endcase
    end

    assign in_ready  = (count != FULL);
    assign out_valid = (count != EMPTY);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                src1_mem[i]    <= 64'd0;
                src2_mem[i]    <= 64'd0;
                ctl_mem[i]     <= 4'd0;
                rd_mem[i]      <= 5'd0;
                illegal_mem[i] <= 1'b0;
            end
        end else if (flush) begin
            count  <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                src1_mem[wr_ptr]    <= sel_src1;
                src2_mem[wr_ptr]    <= sel_src2;
                ctl_mem[wr_ptr]     <= sel_ctl;
                rd_mem[wr_ptr]      <= in_rd;
                illegal_mem[wr_ptr] <= sel_illegal;
                wr_ptr              <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case (count)
                EMPTY: if (push) count <= ONE;
                ONE: begin
                    if (push && !pop)      count <= FULL;
                    else if (pop && !push) count <= EMPTY;
                end
                FULL:    if (pop) count <= ONE;
                default: count <= EMPTY;
            endcase
        end
    end

    // head entry feeds the adder straight from the registers, no input bypass
    assign out_src1    = src1_mem[rd_ptr];
    assign out_src2    = src2_mem[rd_ptr];
    assign out_control = ctl_mem[rd_ptr];
    assign out_rd      = rd_mem[rd_ptr];
    assign out_illegal = illegal_mem[rd_ptr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed scenarios followed by random traffic,
// with a queue-based reference FIFO checked at every falling edge.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'd0;
    logic [63:0] in_rs1 = 64'd0;
    logic [63:0] in_rs2 = 64'd0;
    logic [63:0] in_imm = 64'd0;
    logic [63:0] in_pc = 64'd0;
    logic [4:0]  in_rd = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_src1;
    logic [63:0] out_src2;
    logic [3:0]  out_control;
    logic [4:0]  out_rd;
    logic        out_illegal;

    alu_issue_stage #(.DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_src1(out_src1), .out_src2(out_src2), .out_control(out_control),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] s1;
        logic [63:0] s2;
        logic [3:0]  ctl;
        logic        ill;
        logic [4:0]  rd;
    } entry_t;

    entry_t q[$];
    int vectors = 0;
    int miscompares = 0;

    function automatic entry_t ref_entry(input logic [3:0] op, input logic [63:0] rs1,
                                         input logic [63:0] rs2, input logic [63:0] imm,
                                         input logic [63:0] pc, input logic [4:0] rd);
        entry_t e;
        e = '0;
        e.rd = rd;
        case (op)
            0:  begin e.s1 = rs1;   e.s2 = rs2;   e.ctl = 0; end
            1:  begin e.s1 = rs1;   e.s2 = rs2;   e.ctl = 1; end
            2:  begin e.s1 = rs1;   e.s2 = imm;   e.ctl = 0; end
            3:  begin e.s1 = rs1;   e.s2 = rs2;   e.ctl = 2; end
            4:  begin e.s1 = rs1;   e.s2 = rs2;   e.ctl = 3; end
            5:  begin e.s1 = rs1;   e.s2 = imm;   e.ctl = 2; end
            6:  begin e.s1 = 0;     e.s2 = imm;   e.ctl = 0; end
            7:  begin e.s1 = pc;    e.s2 = imm;   e.ctl = 0; end
            8:  begin e.s1 = pc;    e.s2 = 64'd4; e.ctl = 0; end
            9:  begin e.s1 = rs1;   e.s2 = imm;   e.ctl = 4; end
            10: begin e.s1 = rs1;   e.s2 = imm;   e.ctl = 0; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // reference FIFO: accepts while it holds fewer than two, flush and reset empty it
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            int n;
            n = q.size();
            if (n > 0 && out_ready) void'(q.pop_front());
            if (in_valid && n < 2)
                q.push_back(ref_entry(in_op, in_rs1, in_rs2, in_imm, in_pc, in_rd));
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            entry_t act;
            chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
            chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
            if (q.size() != 0 && out_valid) begin
                act = {out_src1, out_src2, out_control, out_illegal, out_rd};
                vectors++;
                if (act !== q[0]) begin
                    miscompares++;
                    $display("FAIL head_entry got s1=%h s2=%h ctl=%0d ill=%0b rd=%0d expected s1=%h s2=%h ctl=%0d ill=%0b rd=%0d",
                             out_src1, out_src2, out_control, out_illegal, out_rd,
                             q[0].s1, q[0].s2, q[0].ctl, q[0].ill, q[0].rd);
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [3:0] op, input logic [63:0] rs1,
                       input logic [63:0] rs2, input logic [63:0] imm, input logic [63:0] pc,
                       input logic [4:0] rd, input logic ordy, input logic fl);
        in_valid = v; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pc = pc;
        in_rd = rd; out_ready = ordy; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 0, 0, 0, 0, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        chk({tag, "_src1"}, out_src1, 64'd0);
        chk({tag, "_src2"}, out_src2, 64'd0);
        chk({tag, "_ctl_rd_ill"}, {54'd0, out_control, out_rd, out_illegal}, 64'd0);
    endtask

    localparam logic [63:0] IMM = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [63:0] PC  = 64'h0000_0000_8000_0000;

    initial begin
        logic hold;
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // op 0 then sweep of ops 1..10
        cyc(1'b1, 4'd0, 64'd5, 64'd7, 64'd0, 64'd0, 5'd1, 1'b1, 1'b0);
        for (int op = 1; op <= 10; op++)
            cyc(1'b1, op[3:0], 64'h10, 64'h20, IMM, PC, op[4:0], 1'b1, 1'b0);
        idle(3);

        // back-pressure: third instruction waits until space frees up
        cyc(1'b1, 4'd0, 64'd1, 64'd1, 0, 0, 5'd1, 1'b0, 1'b0);
        cyc(1'b1, 4'd0, 64'd2, 64'd2, 0, 0, 5'd2, 1'b0, 1'b0);
        cyc(1'b1, 4'd0, 64'd3, 64'd3, 0, 0, 5'd3, 1'b0, 1'b0);
        cyc(1'b1, 4'd0, 64'd3, 64'd3, 0, 0, 5'd3, 1'b0, 1'b0);
        cyc(1'b1, 4'd0, 64'd3, 64'd3, 0, 0, 5'd3, 1'b1, 1'b0);
        cyc(1'b1, 4'd0, 64'd3, 64'd3, 0, 0, 5'd3, 1'b1, 1'b0);
        idle(3);

        // steady state at one entry with push and pop every cycle
        cyc(1'b1, 4'd2, 64'd100, 0, 64'd1, 0, 5'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++)
            cyc(1'b1, 4'd2, 64'd100, 0, k, 0, k[4:0], 1'b1, 1'b0);
        idle(2);

        // flush a full FIFO with a simultaneous push
        cyc(1'b1, 4'd1, 64'd11, 64'd12, 0, 0, 5'd11, 1'b0, 1'b0);
        cyc(1'b1, 4'd1, 64'd13, 64'd14, 0, 0, 5'd12, 1'b0, 1'b0);
        cyc(1'b1, 4'd7, 64'd0, 64'd0, 64'd99, 64'd77, 5'd17, 1'b0, 1'b1);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        idle(2);

        // unrecognised op is queued as illegal with zero operands
        cyc(1'b1, 4'd13, 64'hAAAA, 64'hBBBB, 64'hCCCC, 64'hDDDD, 5'd9, 1'b0, 1'b0);
        chk("illegal_flag", {63'd0, out_illegal}, 64'd1);
        chk("illegal_rd", {59'd0, out_rd}, 64'd9);
        idle(2);

        // asynchronous reset while full
        cyc(1'b1, 4'd0, 64'd21, 64'd22, 0, 0, 5'd21, 1'b0, 1'b0);
        cyc(1'b1, 4'd0, 64'd23, 64'd24, 0, 0, 5'd22, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // random traffic with handshake-compliant holds
        hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_op    = 4'($urandom_range(0, 15));
                in_rs1   = {$urandom, $urandom};
                in_rs2   = {$urandom, $urandom};
                in_imm   = {$urandom, $urandom};
                in_pc    = {$urandom, $urandom};
                in_rd    = 5'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            @(negedge clk);
            hold = in_valid && !in_ready && !flush;
            @(posedge clk);
            #1;
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-stage issue buffer that sits directly upstream of the ALU adder. It accepts decoded integer instructions from the decode stage over a valid/ready handshake, selects the two 64-bit adder operands, and generates the 4-bit adder control code. Results are held in a 2-entry registered FIFO so that decode is decoupled from execute back-pressure. The buffer's head entry drives the adder's `src1`, `src2` and `control` inputs directly.

## Interface
- `DEPTH`, 2: FIFO entries. Fixed at 2; other values are unsupported.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous pipeline flush; empties the FIFO.
- `in_valid` input 1: decode presents an instruction.
- `in_ready` output 1: stage can accept an instruction.
- `in_op` input 4: operation class (encoding in Operation).
- `in_rs1` input 64: rs1 register value.
- `in_rs2` input 64: rs2 register value.
- `in_imm` input 64: sign-extended immediate.
- `in_pc` input 64: instruction PC.
- `in_rd` input 5: destination register tag, passed through.
- `out_valid` output 1: head entry is valid.
- `out_ready` input 1: execute consumes the head entry.
- `out_src1` output 64: adder `src1`.
- `out_src2` output 64: adder `src2`.
- `out_control` output 4: adder control code.
- `out_rd` output 5: destination tag.
- `out_illegal` output 1: the `in_op` was unrecognised.

## Operation
- Operand selection is combinational on the input side. The result, as {src1, src2, control, illegal}, is written into the FIFO tail when the instruction is pushed. `in_rd` is stored alongside it.
- `in_op` encoding:
  - 0 ADD: rs1, rs2, ctl 0
  - 1 SUB: rs1, rs2, ctl 1
  - 2 ADDI: rs1, imm, ctl 0
  - 3 ADDW: rs1, rs2, ctl 2
  - 4 SUBW: rs1, rs2, ctl 3
  - 5 ADDIW: rs1, imm, ctl 2
  - 6 LUI: 0, imm, ctl 0
  - 7 AUIPC: pc, imm, ctl 0
  - 8 JAL link: pc, 64'd4, ctl 0
  - 9 JALR target: rs1, imm, ctl 4
  - 10 LD/ST address: rs1, imm, ctl 0
  - 11–15: src1 = 0, src2 = 0, ctl 0, illegal = 1. The entry is still queued, not dropped.
- Push condition: `in_valid && in_ready && !flush`.
- Pop condition: `out_valid && out_ready && !flush`.
- Storage: two entry registers, 1-bit read and write pointers that wrap 1→0, and a 2-bit count in the range 0..2.
- `in_ready` = (count != 2). It is a registered-state function only, with no combinational path from `out_ready`.
- `out_valid` = (count != 0). Output data comes from the entry at the read pointer.
- States, by count:
  - EMPTY (0): push → ONE.
  - ONE (1): push only → FULL; pop only → EMPTY; push and pop together → ONE. In that case the head advances, and the new entry becomes head on the next cycle.
  - FULL (2): push is impossible; pop → ONE.
- `flush` takes priority over all other events. It sets count to 0 and both pointers to 0 on the next edge. A simultaneous push or pop is discarded.
- When `out_valid` = 0, the output data buses hold stale values. Checkers compare them only while `out_valid` = 1.

## Timing
- Reset (`rst_n` = 0, asynchronous):
  - count = 0 and both pointers = 0.
  - All entry registers are cleared to 0.
  - Outputs: `out_valid` = 0, `in_ready` = 1, `out_src1` = `out_src2` = 0, `out_control` = 0, `out_rd` = 0, `out_illegal` = 0.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency: an instruction pushed at edge N is visible with `out_valid` = 1 in cycle N+1, assuming it is the head. This is one cycle minimum.
- Throughput: one instruction per cycle when `out_ready` is held at 1.
- After a stall, a FULL→ONE pop raises `in_ready` in the cycle after the pop edge.
- Handshake rules:
  - Upstream must hold `in_*` stable while `in_valid` && !`in_ready`.
  - This block holds its `out_*` values stable while `out_valid` && !`out_ready`.
- There is no combinational path from any input to any output. All outputs are registered or decoded from registered count and pointers.

## Test plan
- Reset, then push op 0 with rs1 = 5, rs2 = 7 → next cycle `out_valid` = 1, src1 = 5, src2 = 7, control = 0. Sweep ops 1–10 with rs1 = 0x10, rs2 = 0x20, imm = 0xFFFF_FFFF_FFFF_FFF8, pc = 0x8000_0000; each op must produce the listed src1, src2 and control.
- Hold `out_ready` = 0 and push 3 instructions (rd = 1, 2, 3) → rd 1 and 2 accepted, `in_ready` = 0 after the second push. Release `out_ready` → pops occur in order 1, 2, then 3 is accepted, with no loss or duplication.
- Count = 1, apply simultaneous push and pop with `out_ready` = 1 for 20 cycles with incrementing rd → `out_rd` increments by 1 each cycle and count stays at 1.
- FIFO FULL, assert `flush` together with `in_valid` = 1 → next cycle `out_valid` = 0, `in_ready` = 1, and the flushed-cycle instruction never appears.
- Push op 13 with rd = 9 → `out_illegal` = 1, src1 = 0, src2 = 0, control = 0, `out_rd` = 9.
- FIFO FULL, drop `rst_n` between clock edges → `out_valid` = 0 and `in_ready` = 1 before the next edge.
